leaf_out_port_scheduler: RTL

- Schedules up to NUM_OUT_PORTS user output streams (TDATA/TVALID/TREADY style, 32-bit payload) onto the single 49-bit BFT packet output of a leaf.
- Grants one stream per cycle by round-robin, gated by per-port destination configuration and per-port credit (remote BRAM freespace).
- Sits between the user kernel outputs and the leaf interface packet mux.
- Configures each port's destination (leaf, port) at runtime and handles the credit returns that replenish the remote buffer.

---
 rtl/leaf_pkg.sv | 40 ++++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/leaf_out_port_scheduler.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/leaf_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : leaf_pkg
// Purpose  : Shared definitions for the leaf BFT packet format and the
//            output-port scheduler state machine.
//            Packet layout (49 bits):
//              [48]    valid
//              [47:43] destination leaf
//              [42:39] destination port
//              [38:32] remote buffer address
//              [31:0]  payload
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package leaf_pkg;

    localparam int c_PKT_PAYLOAD_BITS = 32;
    localparam int c_PKT_ADDR_BITS    = 7;
    localparam int c_PKT_PORT_BITS    = 4;
    localparam int c_PKT_LEAF_BITS    = 5;

    localparam int c_PKT_PAYLOAD_LSB  = 0;
    localparam int c_PKT_ADDR_LSB     = 32;
    localparam int c_PKT_PORT_LSB     = 39;
    localparam int c_PKT_LEAF_LSB     = 43;
    localparam int c_PKT_VALID_BIT    = 48;
    localparam int c_PACKET_BITS      = 49;

    // Remote BRAM depth: initial and maximum credit per port.
    localparam int c_REMOTE_DEPTH     = 1 << c_PKT_ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Purely combinational round-robin arbiter. Grants the first
//            asserted request found searching i_ptr, i_ptr+1, ... modulo
//            NUM_REQ. Output is one-hot or zero.
// Ports    : i_req  - request vector
//            i_ptr  - search start index (must be < NUM_REQ)
//            o_gnt  - one-hot grant
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import leaf_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int PTR_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [PTR_BITS-1:0] i_ptr,
    output logic [NUM_REQ-1:0]  o_gnt
);

    // One extra bit so ptr + offset never overflows before the modulo fold.
    localparam int c_SUM_BITS = PTR_BITS + 1;

    logic [c_SUM_BITS-1:0] w_sum;
    logic [PTR_BITS-1:0]   w_idx;
    logic                  w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + c_SUM_BITS'(k);
            if (w_sum >= c_SUM_BITS'(NUM_REQ)) begin
                w_sum = w_sum - c_SUM_BITS'(NUM_REQ);
            end
            w_idx = w_sum[PTR_BITS-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/leaf_out_port_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : leaf_out_port_scheduler
// Purpose  : Schedules NUM_OUT_PORTS user output streams onto the single BFT
//            packet output of a leaf. One word per cycle is granted by
//            round-robin among ports that are valid, configured and hold
//            remote-buffer credit.
// Ports    : ap_clk, ap_rst_n      - clock, async active-low reset
//            user_tdata/tvalid/tready - user output streams
//            cfg_we/cfg_port/cfg_dst  - runtime destination {leaf, port}
//            credit_vld/credit_port   - credit return (+FREESPACE_UPDATE_SIZE)
//            resend                   - freeze new grants
//            pkt_out/pkt_ready        - {valid, leaf, port, addr, payload}
//            busy                     - output valid or any stream pending
// Revision : 1.0 - initial release
// ============================================================================
module leaf_out_port_scheduler
    import leaf_pkg::*;
#(
    parameter int NUM_OUT_PORTS         = 4,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int PACKET_BITS           = 1 + NUM_LEAF_BITS + NUM_PORT_BITS
                                          + NUM_BRAM_ADDR_BITS + PAYLOAD_BITS
) (
    input  logic                                    ap_clk,
    input  logic                                    ap_rst_n,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   user_tdata,
    input  logic [NUM_OUT_PORTS-1:0]                user_tvalid,
    output logic [NUM_OUT_PORTS-1:0]                user_tready,
    input  logic                                    cfg_we,
    input  logic [2:0]                              cfg_port,
    input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0]  cfg_dst,
    input  logic                                    credit_vld,
    input  logic [2:0]                              credit_port,
    input  logic                                    resend,
    output logic [PACKET_BITS-1:0]                  pkt_out,
    input  logic                                    pkt_ready,
    output logic                                    busy
);

    localparam int c_DST_BITS  = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int c_CRED_BITS = NUM_BRAM_ADDR_BITS + 1;
    localparam int c_SUM_BITS  = c_CRED_BITS + 1;
    localparam int c_PTR_BITS  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int c_DEPTH     = 1 << NUM_BRAM_ADDR_BITS;

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases two clocks after ap_rst_n
    // rises so every flop leaves reset on the same edge.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [NUM_OUT_PORTS-1:0]        r_cfg_valid;
    logic [c_DST_BITS-1:0]           r_dst    [NUM_OUT_PORTS];
    logic [NUM_BRAM_ADDR_BITS-1:0]   r_addr   [NUM_OUT_PORTS];
    logic [c_CRED_BITS-1:0]          r_credit [NUM_OUT_PORTS];
    logic [c_PTR_BITS-1:0]           r_rr_ptr;
    logic [PACKET_BITS-1:0]          r_pkt;

    logic [PAYLOAD_BITS-1:0]         w_tdata      [NUM_OUT_PORTS];
    logic [c_SUM_BITS-1:0]           w_cred_sum   [NUM_OUT_PORTS];
    logic [c_CRED_BITS-1:0]          w_credit_nxt [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0]        w_has_credit;
    logic [NUM_OUT_PORTS-1:0]        w_eligible;
    logic [NUM_OUT_PORTS-1:0]        w_arb_gnt;
    logic [NUM_OUT_PORTS-1:0]        w_grant;
    logic                            w_any_gnt;
    logic                            w_can_accept;
    logic                            w_run;
    logic [c_PTR_BITS-1:0]           w_gnt_idx;
    logic [c_PTR_BITS-1:0]           w_ptr_nxt;
    logic [PAYLOAD_BITS-1:0]         w_sel_data;
    logic [c_DST_BITS-1:0]           w_sel_dst;
    logic [NUM_BRAM_ADDR_BITS-1:0]   w_sel_addr;

    genvar g;
    generate
        for (g = 0; g < NUM_OUT_PORTS; g++) begin : g_unpack
            assign w_tdata[g] = user_tdata[g*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|r_cfg_valid) w_state_nxt = RUN;
            RUN:     if (resend)       w_state_nxt = FREEZE;
            FREEZE:  if (!resend)      w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // resend also masks grants in the cycle it rises, before the FSM has
    // moved to FREEZE, so no word is granted while resend is high.
    assign w_run        = (r_state == RUN) && !resend;
    assign w_can_accept = !r_pkt[PACKET_BITS-1] || pkt_ready;
    assign w_eligible   = user_tvalid & r_cfg_valid & w_has_credit
                          & {NUM_OUT_PORTS{w_run}};

    rr_arbiter #(
        .NUM_REQ  (NUM_OUT_PORTS),
        .PTR_BITS (c_PTR_BITS)
    ) u_rr_arbiter (
        .i_req (w_eligible),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_arb_gnt)
    );

    assign w_grant     = w_can_accept ? w_arb_gnt : '0;
    assign w_any_gnt   = |w_grant;
    assign user_tready = w_grant;

    // One-hot grant to index plus selection of the granted port's fields.
    always_comb begin
        w_gnt_idx  = '0;
        w_sel_data = '0;
        w_sel_dst  = '0;
        w_sel_addr = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (w_arb_gnt[i]) begin
                w_gnt_idx  = c_PTR_BITS'(i);
                w_sel_data = w_tdata[i];
                w_sel_dst  = r_dst[i];
                w_sel_addr = r_addr[i];
            end
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == c_PTR_BITS'(NUM_OUT_PORTS - 1))
                       ? '0 : w_gnt_idx + c_PTR_BITS'(1);

    // ------------------------------------------------------------------
    // Credit arithmetic: -1 per grant, +FREESPACE_UPDATE_SIZE per return,
    // clamped to the remote depth. A grant implies credit >= 1, so the
    // sum cannot underflow.
    // ------------------------------------------------------------------
    always_comb begin
        w_has_credit = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            w_has_credit[i] = (r_credit[i] != '0);
            w_cred_sum[i]   = {1'b0, r_credit[i]}
                              + ((credit_vld && (credit_port == 3'(i)))
                                 ? c_SUM_BITS'(FREESPACE_UPDATE_SIZE) : '0)
                              - c_SUM_BITS'(w_grant[i]);
            w_credit_nxt[i] = (w_cred_sum[i] > c_SUM_BITS'(c_DEPTH))
                              ? c_CRED_BITS'(c_DEPTH)
                              : w_cred_sum[i][c_CRED_BITS-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Per-port configuration, address and credit state. An out-of-range
    // cfg_port/credit_port matches no port and is therefore ignored.
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cfg_valid <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                r_dst[i]    <= '0;
                r_addr[i]   <= '0;
                r_credit[i] <= c_CRED_BITS'(c_DEPTH);
            end
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (cfg_we && (cfg_port == 3'(i))) begin
                    r_dst[i]       <= cfg_dst;
                    r_cfg_valid[i] <= 1'b1;
                end
                if (w_grant[i]) begin
                    r_addr[i] <= r_addr[i] + 1'b1;
                end
                r_credit[i] <= w_credit_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pkt    <= '0;
            r_rr_ptr <= '0;
        end else if (w_any_gnt) begin
            r_pkt    <= {1'b1, w_sel_dst, w_sel_addr, w_sel_data};
            r_rr_ptr <= w_ptr_nxt;
        end else if (pkt_ready) begin
            r_pkt    <= '0;
        end
    end

    assign pkt_out = r_pkt;
    assign busy    = r_pkt[PACKET_BITS-1] | (|user_tvalid);

endmodule
`default_nettype wire
